// File: rtl/spi_word_responder.sv
// SPI mode-0 responder that moves 64-bit command words between the host pins and the CLK domain.
// All SPI pins are oversampled in CLK. Words go least-significant byte first, and each byte goes MSB first.
module spi_word_responder #(
  parameter int WORD_BYTES  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    CLK,
  input  logic                    resetn,
  input  logic                    SCK,
  input  logic                    CS,
  input  logic                    COPI,
  output logic                    CIPO,
  output logic [8*WORD_BYTES-1:0] rx_word,
  output logic                    rx_valid,
  input  logic [8*WORD_BYTES-1:0] tx_word,
  input  logic                    tx_valid,
  output logic                    tx_ready,
  output logic                    busy
);

  localparam int W    = 8 * WORD_BYTES;
  localparam int BC_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(WORD_BYTES - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t r_state, w_state_next;

  logic [SYNC_STAGES-1:0] r_sck_sync, r_cs_sync, r_copi_sync;
  logic                   r_sck_d, r_cs_d;
  logic                   w_sck, w_cs, w_copi;
  logic                   w_sck_rise, w_sck_fall, w_cs_rise;

  logic [2:0]      r_bit_cnt;
  logic [BC_W-1:0] r_byte_cnt;
  logic [7:0]      r_rx_byte;
  logic [W-1:0]    r_rx_accum, r_rx_word, r_tx_shift;
  logic            r_rx_valid, r_tx_ready, r_cipo, r_word_done;

  logic            w_load_entry, w_word_end, w_load_boundary;
  logic [7:0]      w_rx_byte_full;
  logic [W-1:0]    w_tx_stream;

  // Reorders a word into wire order so the serializer only has to shift out the MSB.
  function automatic logic [W-1:0] to_stream(input logic [W-1:0] word);
    logic [W-1:0] s;
    s = '0;
    for (int b = 0; b < WORD_BYTES; b++) s[W-1-8*b -: 8] = word[8*b +: 8];
    return s;
  endfunction

  // NOTE: non-blocking assignments in every clocked block so all flops sample pre-edge values.
  always_ff @(posedge CLK) begin
    if (!resetn) begin
      r_sck_sync  <= '0;
      r_cs_sync   <= '1;
      r_copi_sync <= '0;
      r_sck_d     <= 1'b0;
      r_cs_d      <= 1'b1;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], SCK};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], CS};
      r_copi_sync <= {r_copi_sync[SYNC_STAGES-2:0], COPI};
      r_sck_d     <= r_sck_sync[SYNC_STAGES-1];
      r_cs_d      <= r_cs_sync[SYNC_STAGES-1];
    end
  end

  assign w_sck      = r_sck_sync[SYNC_STAGES-1];
  assign w_cs       = r_cs_sync[SYNC_STAGES-1];
  assign w_copi     = r_copi_sync[SYNC_STAGES-1];
  assign w_sck_rise = w_sck & ~r_sck_d;
  assign w_sck_fall = ~w_sck & r_sck_d;
  assign w_cs_rise  = w_cs & ~r_cs_d;

  always_ff @(posedge CLK) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_state_next;
  end

  // NOTE: next state gets a default before the case so no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (!w_cs) w_state_next = SHIFT;
      SHIFT:   if (w_cs_rise) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  assign w_load_entry    = (r_state == IDLE) && !w_cs;
  assign w_word_end      = (r_state == SHIFT) && w_sck_rise && (r_bit_cnt == 3'd7) &&
                           (r_byte_cnt == LAST_BYTE);
  assign w_load_boundary = w_word_end && !w_cs_rise;
  assign w_rx_byte_full  = {r_rx_byte[6:0], w_copi};
  assign w_tx_stream     = to_stream(tx_valid ? tx_word : '0);

  always_ff @(posedge CLK) begin
    if (!resetn) begin
      r_bit_cnt   <= '0;
      r_byte_cnt  <= '0;
      r_rx_byte   <= '0;
      r_rx_accum  <= '0;
      r_rx_word   <= '0;
      r_tx_shift  <= '0;
      r_rx_valid  <= 1'b0;
      r_tx_ready  <= 1'b0;
      r_cipo      <= 1'b0;
      r_word_done <= 1'b0;
    end else begin
      r_rx_valid  <= 1'b0;
      r_tx_ready  <= 1'b0;
      r_word_done <= 1'b0;
      // The completed word is published one cycle after the final lane is written.
      // This still happens if CS has already released the state machine to IDLE.
      if (r_word_done) begin
        r_rx_word  <= r_rx_accum;
        r_rx_valid <= 1'b1;
      end
      if (w_load_entry) begin
        r_bit_cnt  <= '0;
        r_byte_cnt <= '0;
        r_tx_shift <= w_tx_stream << 1;
        r_cipo     <= w_tx_stream[W-1];
        r_tx_ready <= tx_valid;
      end else if (r_state == SHIFT) begin
        if (w_sck_rise) begin
          r_rx_byte <= w_rx_byte_full;
          r_bit_cnt <= r_bit_cnt + 1'b1;
          if (r_bit_cnt == 3'd7) begin
            r_rx_accum[{r_byte_cnt, 3'b000} +: 8] <= w_rx_byte_full;
            r_byte_cnt <= r_byte_cnt + 1'b1;
            if (w_word_end) begin
              r_byte_cnt  <= '0;
              r_word_done <= 1'b1;
            end
          end
          // At a word boundary the next word is loaded whole.
          // The following SCK fall then drives its first bit.
          if (w_load_boundary) begin
            r_tx_shift <= w_tx_stream;
            r_tx_ready <= tx_valid;
          end
        end else if (w_sck_fall) begin
          r_cipo     <= r_tx_shift[W-1];
          r_tx_shift <= r_tx_shift << 1;
        end
        if (w_cs_rise) r_cipo <= 1'b0;
      end
    end
  end

  assign CIPO     = r_cipo;
  assign rx_word  = r_rx_word;
  assign rx_valid = r_rx_valid;
  assign tx_ready = r_tx_ready;
  assign busy     = resetn & ~w_cs;

endmodule
